// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter sharing the async FIFO write port among NREQ requesters.
// Define WARB_BURST_EN to let an owner keep the port for up to BURST beats; otherwise one beat per grant.
module fifo_wr_arb #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8,
    parameter int BURST = 4
) (
    input  logic                     i_wclk,
    input  logic                     i_wrst,
    input  logic [NREQ-1:0]          i_req,
    input  logic [NREQ*DSIZE-1:0]    i_din,
    output logic [NREQ-1:0]          o_gnt,
    input  logic                     i_wfull,
    output logic                     o_winc,
    output logic [DSIZE-1:0]         o_wdata,
    output logic [$clog2(NREQ)-1:0]  o_owner,
    output logic                     o_busy
);
    // state | meaning
    // IDLE  | no grant; pick next requester round-robin from owner+1
    // BUSY  | owner holds the write port; beats while req[owner] && !wfull
    localparam int OW = $clog2(NREQ);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t          r_state;
    logic [OW-1:0]   r_owner;
    logic [OW-1:0]   w_next_owner;
    logic [OW-1:0]   w_idx;
    logic            w_found;
    logic            w_beat;
    logic            w_last;
    logic [DSIZE-1:0] w_sel_data;

`ifdef WARB_BURST_EN
    localparam int CW = $clog2(BURST) + 1;
    logic [CW-1:0] r_cnt;

    assign w_last = (r_cnt == CW'(BURST - 1));
`else
    // single-beat grants: every beat is the last one
    assign w_last = (BURST >= 1);
`endif

    always_comb begin
        w_next_owner = r_owner;
        w_found      = 1'b0;
        w_idx        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = OW'((int'(r_owner) + k) % NREQ);
            if (!w_found && i_req[w_idx]) begin
                w_found      = 1'b1;
                w_next_owner = w_idx;
            end
        end
    end

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_owner == OW'(i))
                w_sel_data = i_din[i*DSIZE +: DSIZE];
        end
    end

    assign w_beat  = (r_state == S_BUSY) && i_req[r_owner] && !i_wfull;
    assign o_winc  = w_beat;
    assign o_gnt   = w_beat ? (NREQ'(1) << r_owner) : '0;
    assign o_wdata = w_beat ? w_sel_data : '0;
    assign o_owner = r_owner;
    assign o_busy  = (r_state == S_BUSY);

    always_ff @(posedge i_wclk or posedge i_wrst) begin
        if (i_wrst) begin
            r_state <= S_IDLE;
            r_owner <= OW'(NREQ - 1);
`ifdef WARB_BURST_EN
            r_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|i_req) begin
                        r_owner <= w_next_owner;
                        r_state <= S_BUSY;
`ifdef WARB_BURST_EN
                        r_cnt   <= '0;
`endif
                    end
                end
                S_BUSY: begin
                    // owner is kept on exit so it acts as the round-robin pointer
                    if (!i_req[r_owner]) begin
                        r_state <= S_IDLE;
                    end else if (w_beat) begin
`ifdef WARB_BURST_EN
                        r_cnt <= r_cnt + CW'(1);
`endif
                        if (w_last)
                            r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin write-port arbiter that shares the single write port of the asynchronous `fifo` among `NREQ` requesters in the `wclk` domain. Each requester presents data with a valid/accept handshake. The arbiter selects one owner, drives `winc`/`wdata` into the FIFO while honouring `wfull`, and optionally lets the owner hold the port for a bounded burst of beats.

## Interface
- `NREQ`, default 4: number of requesters, ≥ 2.
- `DSIZE`, default 8: data width; matches the FIFO `DSIZE`.
- `BURST`, default 4: maximum beats per grant, ≥ 1.
- `wclk`  in  1: write-domain clock; every register is rising-edge.
- `wrst`  in  1: asynchronous, active-high reset.
- `req`  in  `NREQ`: per-requester valid; held with data until accepted.
- `din`  in  `NREQ*DSIZE`: requester `i` data on bits `[i*DSIZE +: DSIZE]`.
- `gnt`  out  `NREQ`: one-hot accept strobe; `gnt[i]`=1 means `din[i]` is written this cycle.
- `wfull`  in  1: FIFO full flag.
- `winc`  out  1: FIFO write enable.
- `wdata`  out  `DSIZE`: FIFO write data.
- `owner`  out  `$clog2(NREQ)`: current or last owner index.
- `busy`  out  1: arbiter is in state BUSY.

## Operation
- There are two states, IDLE and BUSY. The registers are `state`, `owner`, and a beat counter `cnt` of width `$clog2(BURST)+1`.
- **IDLE:** if `|req`, search round-robin starting at `owner+1` (mod `NREQ`), wrapping, and pick the first set `req`. Load `owner` with it, clear `cnt`, and go to BUSY. If no `req` is set, stay in IDLE. IDLE never asserts `winc` or `gnt`.
- **BUSY:** a beat occurs when `req[owner] && !wfull`. On a beat, `winc`=1, `wdata`=`din[owner]`, `gnt[owner]`=1, and `cnt` increments.
- **BUSY exit to IDLE:** happens when `req[owner]`=0, or when a beat occurs with `cnt == BURST-1`. `owner` is retained so that it serves as the round-robin pointer.
- **Full stall:** in BUSY with `wfull`=1 there is no beat, `cnt` holds, and the owner is kept.
- `winc`, `wdata` and `gnt` are combinational from the registered state, `owner`, `req` and `wfull`. `wdata`=0 whenever `winc`=0.
- At most one `gnt` bit is high in any cycle, and `winc == |gnt`.
- No write is ever issued while `wfull`=1.

## Timing
- **Reset values:** state=IDLE, `owner`=`NREQ-1` (so requester 0 has first priority), `cnt`=0, `busy`=0. `winc`, `gnt` and `wdata` are all 0.
- **Latency:** `req` rising in IDLE gives BUSY on the next edge; the first beat is 1 cycle after `req` is sampled.
- **Throughput:** `BURST` beats per `BURST+1` cycles per grant. There is one IDLE bubble between grants, including a re-grant to the same requester.
- **Handshake:** the requester keeps `req` and `din` stable until it sees `gnt[i]`. It may drop `req` after the `gnt` cycle or withdraw it at any time. A withdrawal ends the grant on the next edge without a write.
- **Wrap-around:** the search from `owner=NREQ-1` continues at index 0.
- **Simultaneous events:** `wfull` rising in the same cycle as the last `req` ends the grant with no write. `wfull` and `req` are sampled combinationally in the same cycle.
- **Reset mid-burst:** `winc` and `gnt` fall asynchronously with `wrst`. A partially written burst is not resumed, and arbitration restarts from requester 0.

## Configuration
- `WARB_BURST_EN` **defined:** grants last up to `BURST` beats, as described above.
- `WARB_BURST_EN` **undefined:** every grant is exactly one beat, regardless of `BURST`. BUSY exits after the first beat, `cnt` is not implemented, and throughput is 1 beat per 2 cycles.

## Test plan
- **Reset priority:** after reset, `req`=4'b1111 with `din[i]`=8'h10+i and no `wfull`. Required: beats 8'h10 through 8'h13 in requester order 0,1,2,3 (burst build, each requester held). With `BURST`=1 or the macro undefined, the written order is 0,1,2,3 interleaved with IDLE bubbles.
- **Burst cap:** requester 2 holds `req` for 10 cycles with `BURST`=4. Required: exactly 4 consecutive `gnt[2]`, then 1 IDLE cycle, then re-grant to requester 2.
- **Full stall:** `wfull`=1 for 3 cycles mid-burst after 2 beats. Required: `winc`=0 for those 3 cycles, `owner` unchanged, then 2 more beats, then exit.
- **Withdrawal:** the owner drops `req` while `wfull`=1. Required: no write, IDLE on the next edge, and the next requester is selected.
- **Wrap-around:** only requesters 3 and 0 request, with `owner`=2 prior. Required: grant to 3, then grant to 0.
- **Async reset mid-burst:** assert `wrst` between clock edges during a beat. Required: `winc`, `gnt` and `busy` are 0 immediately, `owner`=`NREQ-1`, and the first grant after release goes to the lowest-index requester.
